// File: rtl/spi_master_tx16.sv
// spi_master_tx16: SPI mode-0 master sending one 16-bit word per start pulse, MSB first,
// while shifting in 16 bits from miso; all outputs registered.
module spi_master_tx16 #(
    parameter int CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] tx_data,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        ss_n,
    output logic [15:0] rx_data,
    output logic        tx_ready,
    output logic        tx_done
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   tx_sr_q, tx_sr_d;
    logic [15:0]   rx_sr_q, rx_sr_d;
    logic [15:0]   rx_data_q, rx_data_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          ss_n_q, ss_n_d;
    logic          tx_ready_q, tx_ready_d;
    logic          tx_done_q, tx_done_d;
    logic          div_last;

    assign div_last = div_q == DIV_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            tx_ready_q <= tx_ready_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q + 1'b1;
        bit_d      = bit_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        tx_ready_d = tx_ready_q;
        tx_done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (start) begin
                    state_d    = S_SETUP;
                    tx_sr_d    = tx_data;
                    bit_d      = 4'd15;
                    ss_n_d     = 1'b0;
                    mosi_d     = tx_data[15];
                    tx_ready_d = 1'b0;
                end
            end
            S_SETUP, S_LOW: begin
                // rising SCLK: slave data is sampled on the same edge sclk goes high
                if (div_last) begin
                    state_d = S_HIGH;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    rx_sr_d = {rx_sr_q[14:0], miso};
                end
            end
            S_HIGH: begin
                if (div_last) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == 4'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_LOW;
                        tx_sr_d = {tx_sr_q[14:0], 1'b0};
                        mosi_d  = tx_sr_q[14];
                        bit_d   = bit_q - 4'd1;
                    end
                end
            end
            S_HOLD: begin
                if (div_last) begin
                    state_d    = S_IDLE;
                    div_d      = '0;
                    ss_n_d     = 1'b1;
                    tx_ready_d = 1'b1;
                    tx_done_d  = 1'b1;
                    rx_data_d  = rx_sr_q;
                    mosi_d     = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
        endcase
    end

    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;
    assign rx_data  = rx_data_q;
    assign tx_ready = tx_ready_q;
    assign tx_done  = tx_done_q;
endmodule

// File: tb/tb_spi_master_tx16.sv
// tb_spi_master_tx16: randomized frame checks against a frame-level model of the SPI master
// (bit order, phase counts, mosi duty, received word, handshake timing, reset behaviour).
module tb_spi_master_tx16;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] tx_data = '0;
    logic        miso;
    logic        sclk, mosi, ss_n, tx_ready, tx_done;
    logic [15:0] rx_data;

    int          miso_mode = 0;
    logic [15:0] slave_word = '0;
    int          kk = 0;
    int          checks = 0;
    int          errors = 0;

    spi_master_tx16 #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .miso(miso),
        .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // slave model: presents slave_word MSB first, advancing after each rising sclk
    always @(negedge ss_n or posedge sclk) begin
        if (sclk) kk <= kk + 1;
        else kk <= 0;
    end

    assign miso = (miso_mode == 0) ? mosi :
                  (miso_mode == 1) ? 1'b1 :
                  (kk < 16) ? slave_word[4'(15 - kk)] : 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic drive_start(input string nm, input logic [15:0] w);
        @(negedge clk);
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_start got %b exp 1", nm, tx_ready);
        end
        checks++;
        start = 1'b1;
        tx_data = w;
        @(negedge clk);
        start = 1'b0;
        tx_data = 16'($urandom);
    endtask

    // entered at the first sample after the accepting edge
    task automatic check_frame(input string nm, input logic [15:0] w, input logic [15:0] exp_rx,
                               input int poke_at, input bit chain, input logic [15:0] w2);
        int low, rises, done_n, unstable, ones, rx_glitch, exp_ones;
        logic [15:0] bits, rx_before;
        logic prev_sclk, prev_mosi;
        low = 0; rises = 0; done_n = 0; unstable = 0; ones = 0; rx_glitch = 0;
        bits = '0; prev_sclk = 1'b0; prev_mosi = mosi; rx_before = rx_data;
        exp_ones = D * (2 * $countones(w) + int'(w[0]));
        for (int n = 1; n <= 40 * D; n++) begin
            if (n == poke_at) begin
                start = 1'b1;
                tx_data = 16'h1234;
            end else if (n == poke_at + 1) begin
                start = 1'b0;
            end
            if (rx_data !== rx_before && tx_done !== 1'b1) rx_glitch++;
            if (!ss_n) low++;
            if (!ss_n && mosi) ones++;
            if (sclk && !prev_sclk) begin
                rises++;
                bits = {bits[14:0], mosi};
            end
            if (sclk && mosi !== prev_mosi) unstable++;
            if (tx_done) begin
                done_n = n;
                break;
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
            @(negedge clk);
        end
        if (done_n != 33 * D + 1) begin
            errors++;
            $display("FAIL %s done_cycle got %0d exp %0d", nm, done_n, 33 * D + 1);
        end
        checks++;
        if (low != 33 * D) begin
            errors++;
            $display("FAIL %s ss_low_cycles got %0d exp %0d", nm, low, 33 * D);
        end
        checks++;
        if (rises != 16) begin
            errors++;
            $display("FAIL %s sclk_rises got %0d exp 16", nm, rises);
        end
        checks++;
        if (bits !== w) begin
            errors++;
            $display("FAIL %s mosi_bits got %h exp %h", nm, bits, w);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL %s mosi_unstable_high got %0d exp 0", nm, unstable);
        end
        checks++;
        if (ones != exp_ones) begin
            errors++;
            $display("FAIL %s mosi_high_cycles got %0d exp %0d", nm, ones, exp_ones);
        end
        checks++;
        if (rx_glitch != 0) begin
            errors++;
            $display("FAIL %s rx_changed_mid_frame got %0d exp 0", nm, rx_glitch);
        end
        checks++;
        if (rx_data !== exp_rx) begin
            errors++;
            $display("FAIL %s rx_data got %h exp %h", nm, rx_data, exp_rx);
        end
        checks++;
        if ({tx_ready, ss_n, sclk, mosi} !== 4'b1100) begin
            errors++;
            $display("FAIL %s done_outputs got %b exp 1100", nm, {tx_ready, ss_n, sclk, mosi});
        end
        checks++;
        if (chain) begin
            start = 1'b1;
            tx_data = w2;
            @(negedge clk);
            start = 1'b0;
            tx_data = 16'($urandom);
            if ({ss_n, tx_ready, tx_done} !== 3'b000) begin
                errors++;
                $display("FAIL %s chained_start got %b exp 000", nm, {ss_n, tx_ready, tx_done});
            end
            checks++;
        end else begin
            repeat (4) begin
                @(negedge clk);
                if ({tx_done, ss_n, tx_ready} !== 3'b011 || rx_data !== exp_rx) begin
                    errors++;
                    $display("FAIL %s post_idle got %b/%h exp 011/%h", nm,
                             {tx_done, ss_n, tx_ready}, rx_data, exp_rx);
                end
                checks++;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if ({ss_n, sclk, tx_ready, tx_done, mosi} !== 5'b10100 || rx_data !== 16'h0) begin
                errors++;
                $display("FAIL reset_idle got %b/%h exp 10100/0000",
                         {ss_n, sclk, tx_ready, tx_done, mosi}, rx_data);
            end
            checks++;
        end
    endtask

    task automatic test_loopback();
        miso_mode = 0;
        drive_start("loop2A5C", 16'h2A5C);
        check_frame("loop2A5C", 16'h2A5C, 16'h2A5C, 0, 1'b0, 16'h0);
    endtask

    task automatic test_random_loopback();
        logic [15:0] w;
        miso_mode = 0;
        repeat (4) begin
            w = 16'($urandom);
            drive_start("loop_rand", w);
            check_frame("loop_rand", w, w, 0, 1'b0, 16'h0);
        end
    endtask

    task automatic test_miso_high();
        miso_mode = 1;
        drive_start("miso_high", 16'h0000);
        check_frame("miso_high", 16'h0000, 16'hFFFF, 0, 1'b0, 16'h0);
    endtask

    task automatic test_slave_random();
        logic [15:0] w;
        miso_mode = 2;
        repeat (3) begin
            w = 16'($urandom);
            slave_word = 16'($urandom);
            drive_start("slave_rand", w);
            check_frame("slave_rand", w, slave_word, 0, 1'b0, 16'h0);
        end
    endtask

    task automatic test_ignored_start();
        logic [15:0] w;
        miso_mode = 0;
        w = 16'($urandom) ^ 16'h8001;
        drive_start("ignored", w);
        check_frame("ignored", w, w, 10, 1'b0, 16'h0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        miso_mode = 0;
        w = 16'($urandom);
        drive_start("b2b_first", w);
        check_frame("b2b_first", w, w, 0, 1'b1, 16'h270F);
        check_frame("b2b_second", 16'h270F, 16'h270F, 0, 1'b0, 16'h0);
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] w;
        miso_mode = 0;
        w = 16'($urandom) | 16'h0100;
        drive_start("rst_mid", w);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        #1;
        if ({ss_n, sclk, tx_ready, tx_done, mosi} !== 5'b10100 || rx_data !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_async got %b/%h exp 10100/0000",
                     {ss_n, sclk, tx_ready, tx_done, mosi}, rx_data);
        end
        checks++;
        repeat (3) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || ss_n !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_hold got %b%b exp 01", tx_done, ss_n);
            end
            checks++;
        end
        rst = 1'b0;
        repeat (40 * D) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || ss_n !== 1'b1 || rx_data !== 16'h0) begin
                errors++;
                $display("FAIL rst_mid_quiet got %b%b/%h exp 01/0000", tx_done, ss_n, rx_data);
            end
            checks++;
        end
        w = 16'($urandom);
        drive_start("rst_after", w);
        check_frame("rst_after", w, w, 0, 1'b0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_random_loopback();
        test_miso_high();
        test_slave_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
